// File: rtl/lm75_i2c_responder.sv
// -----------------------------------------------------------------------------
// lm75_i2c_responder
//
// I2C target that emulates an LM75 temperature sensor on an open-drain bus.
// It holds the LM75 register set (temperature, config, THYST, TOS) and drives
// the overtemperature output. It is used in place of a real sensor for
// FPGA-only builds and loopback tests of the I2C temperature reader.
//
// Ports:
//   clk      system clock
//   rst      asynchronous, active-low reset
//   scl_in   SCL pad input
//   sda_in   SDA pad input
//   sda_oe   1 = pull SDA low, 0 = release (SDA is never driven high)
//   temp_in  live temperature, signed 9 bits, 0.5 degC per LSB
//   os       overtemperature output, polarity selected by config[2]
//   busy     high from START through STOP
// -----------------------------------------------------------------------------
module lm75_i2c_responder #(
   parameter logic [6:0] ADDR        = 7'h48,
   parameter int         SYNC_STAGES = 2,        // must be >= 2
   parameter logic [8:0] THYST_RST   = 9'd150,
   parameter logic [8:0] TOS_RST     = 9'd160
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   input  logic [8:0] temp_in,
   output logic       os,
   output logic       busy
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_PTR,
      S_PTR_ACK,
      S_WDATA,
      S_WDATA_ACK,
      S_RDATA,
      S_RDATA_ACK,
      S_WAIT_STOP
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchronizers and bus condition detection
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_prev;
   logic                   sda_flt;   // SDA as seen while SCL is high

   logic scl_s, sda_s;
   logic scl_rise, scl_fall;
   logic start_det, stop_det;

   assign scl_s    = scl_sync[SYNC_STAGES-1];
   assign sda_s    = sda_sync[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_prev;
   assign scl_fall = ~scl_s & scl_prev;

   // Requiring SCL high on two consecutive cycles keeps a data change made
   // during SCL low from looking like START/STOP on the following rising edge.
   assign start_det = scl_s & scl_prev & sda_flt & ~sda_s;
   assign stop_det  = scl_s & scl_prev & ~sda_flt & sda_s;

   // NOTE: every register, including the synchronizer chains, has an async
   // reset here; this block holds no memory array, so nothing is left unreset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_flt  <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make every flop in this chain sample
         // the pre-edge value, which is what gives a real multi-stage delay.
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_prev <= scl_s;
         if (scl_s)
            sda_flt <= sda_s;
      end
   end

   // ---------------------------------------------------------------------------
   // Register file state
   // ---------------------------------------------------------------------------
   state_t     state;
   logic [7:0] shift_reg;
   logic [3:0] bit_cnt;
   logic [7:0] tx_byte;
   logic       rw;
   logic       rd_idx;       // 0 = MSB byte, 1 = LSB byte of a 9-bit register
   logic [1:0] wr_idx;       // data bytes seen in this write, saturates at 2
   logic [7:0] hold_b1;      // first byte of a pending THYST/TOS write
   logic       master_ack;
   logic [1:0] pointer;
   logic [7:0] cfg_reg;
   logic [8:0] thyst;
   logic [8:0] tos;
   logic [8:0] temp_reg;
   logic [8:0] rd_snap;
   logic       alarm;

   logic       byte_done;
   logic [8:0] rd_word;
   logic [7:0] rd_hi, rd_lo;

   assign byte_done = scl_fall && (bit_cnt == 4'd8);

   // Read byte selection for the current pointer.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latch.
      rd_word = '0;
      case (pointer)
         2'd0:    rd_word = rd_snap;
         2'd2:    rd_word = thyst;
         2'd3:    rd_word = tos;
         default: rd_word = '0;
      endcase
      rd_hi = rd_word[8:1];
      rd_lo = {rd_word[0], 7'b0};
      if (pointer == 2'd1) begin
         rd_hi = cfg_reg;
         rd_lo = cfg_reg;
      end
   end

   // ---------------------------------------------------------------------------
   // Protocol FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         tx_byte    <= '0;
         rw         <= 1'b0;
         rd_idx     <= 1'b0;
         wr_idx     <= '0;
         hold_b1    <= '0;
         master_ack <= 1'b0;
         pointer    <= '0;
         cfg_reg    <= '0;
         thyst      <= THYST_RST;
         tos        <= TOS_RST;
         rd_snap    <= '0;
         sda_oe     <= 1'b0;
         busy       <= 1'b0;
      end else if (start_det) begin
         // Repeated START also lands here; a pending THYST/TOS byte is dropped.
         state   <= S_ADDR;
         bit_cnt <= '0;
         wr_idx  <= '0;
         sda_oe  <= 1'b0;
         busy    <= 1'b1;
      end else if (stop_det) begin
         state  <= S_IDLE;
         sda_oe <= 1'b0;
         busy   <= 1'b0;
      end else begin
         // Receive shifter shared by all master-to-target byte states.
         if ((state == S_ADDR || state == S_PTR || state == S_WDATA) &&
             scl_rise && bit_cnt != 4'd8) begin
            shift_reg <= {shift_reg[6:0], sda_s};
            bit_cnt   <= bit_cnt + 4'd1;
         end

         case (state)
            S_ADDR: begin
               if (byte_done) begin
                  bit_cnt <= '0;
                  if (shift_reg[7:1] == ADDR) begin
                     state  <= S_ADDR_ACK;
                     sda_oe <= 1'b1;
                     rw     <= shift_reg[0];
                     // The snapshot keeps MSB and LSB of one read coherent.
                     if (shift_reg[0])
                        rd_snap <= temp_reg;
                  end else begin
                     state <= S_WAIT_STOP;
                  end
               end
            end

            S_ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt <= '0;
                  if (rw) begin
                     state   <= S_RDATA;
                     rd_idx  <= 1'b0;
                     tx_byte <= rd_hi;
                     sda_oe  <= ~rd_hi[7];
                  end else begin
                     state  <= S_PTR;
                     sda_oe <= 1'b0;
                  end
               end
            end

            S_PTR: begin
               if (byte_done) begin
                  bit_cnt <= '0;
                  pointer <= shift_reg[1:0];
                  state   <= S_PTR_ACK;
                  sda_oe  <= 1'b1;
               end
            end

            S_PTR_ACK: begin
               if (scl_fall) begin
                  state   <= S_WDATA;
                  sda_oe  <= 1'b0;
                  wr_idx  <= '0;
                  bit_cnt <= '0;
               end
            end

            S_WDATA: begin
               if (byte_done) begin
                  bit_cnt <= '0;
                  state   <= S_WDATA_ACK;
                  sda_oe  <= 1'b1;
                  case (pointer)
                     2'd1: if (wr_idx == 2'd0) cfg_reg <= shift_reg;
                     2'd2: begin
                        if (wr_idx == 2'd0)      hold_b1 <= shift_reg;
                        else if (wr_idx == 2'd1) thyst   <= {hold_b1, shift_reg[7]};
                     end
                     2'd3: begin
                        if (wr_idx == 2'd0)      hold_b1 <= shift_reg;
                        else if (wr_idx == 2'd1) tos     <= {hold_b1, shift_reg[7]};
                     end
                     default: ;
                  endcase
                  if (wr_idx != 2'd2)
                     wr_idx <= wr_idx + 2'd1;
               end
            end

            S_WDATA_ACK: begin
               if (scl_fall) begin
                  state  <= S_WDATA;
                  sda_oe <= 1'b0;
               end
            end

            S_RDATA: begin
               if (scl_rise)
                  bit_cnt <= bit_cnt + 4'd1;
               else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     bit_cnt <= '0;
                     state   <= S_RDATA_ACK;
                     sda_oe  <= 1'b0;
                  end else begin
                     sda_oe  <= ~tx_byte[6];
                     tx_byte <= {tx_byte[6:0], 1'b0};
                  end
               end
            end

            S_RDATA_ACK: begin
               if (scl_rise)
                  master_ack <= ~sda_s;
               else if (scl_fall) begin
                  if (master_ack) begin
                     state   <= S_RDATA;
                     rd_idx  <= ~rd_idx;
                     tx_byte <= rd_idx ? rd_hi : rd_lo;
                     sda_oe  <= rd_idx ? ~rd_hi[7] : ~rd_lo[7];
                  end else begin
                     state <= S_WAIT_STOP;
                  end
               end
            end

            S_WAIT_STOP: sda_oe <= 1'b0;

            default: state <= S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Temperature register and comparator
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         temp_reg <= '0;
         alarm    <= 1'b0;
         os       <= 1'b1;
      end else begin
         if (!cfg_reg[0])
            temp_reg <= temp_in;
         if ($signed(temp_reg) > $signed(tos))
            alarm <= 1'b1;
         else if ($signed(temp_reg) < $signed(thyst))
            alarm <= 1'b0;
         os <= cfg_reg[2] ? alarm : ~alarm;
      end
   end

endmodule
